// File: rtl/tictactoe_game_ctrl.sv
// Tic-tac-toe game controller: synchronized push buttons drive a cursor/placement FSM
// that scans one board line per cycle after each move. Define TTT_BTN_DEBOUNCE_EN for debounce.
module tictactoe_game_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iBtnUp,
    input  logic        iBtnDown,
    input  logic        iBtnLeft,
    input  logic        iBtnRight,
    input  logic        iBtnSelect,
    output logic [3:0]  oMarkedBlockPosX,
    output logic [3:0]  oMarkedBlockPosY,
    output logic [0:17] oSymVector,
    output logic [14:0] oWinSeqPos,
    output logic        oWinFlag,
    output logic        oDrawFlag,
    output logic        oTurn
);

    typedef enum logic [1:0] {S_PLAY, S_CHECK, S_WIN, S_DRAW} state_e;

    localparam int NB = 5;

    // Bit order doubles as the action priority: select, up, down, left, right.
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] sync1_q, sync2_q;
    logic [NB-1:0] level;
    logic [NB-1:0] level_prev_q;
    logic [NB-1:0] press;

    assign btn_raw = {iBtnSelect, iBtnUp, iBtnDown, iBtnLeft, iBtnRight};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef TTT_BTN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar gi = 0; gi < NB; gi++) begin : g_debounce
        logic [CNT_W-1:0] cnt_q;
        logic             db_q;

        // The level flips only after DEBOUNCE_CYCLES consecutive differing samples.
        always_ff @(posedge Clock or negedge Reset) begin
            if (!Reset) begin
                cnt_q <= '0;
                db_q  <= 1'b0;
            end else if (sync2_q[gi] == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                db_q  <= sync2_q[gi];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign level[gi] = db_q;
    end
`else
    assign level = sync2_q;

    // DEBOUNCE_CYCLES has no effect without the filter.
    if (DEBOUNCE_CYCLES == 0) begin : g_no_filter
    end
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            level_prev_q <= '0;
        end else begin
            level_prev_q <= level;
        end
    end

    assign press = level & ~level_prev_q;

    logic p_sel, p_up, p_down, p_left, p_right;
    assign {p_sel, p_up, p_down, p_left, p_right} = press;

    state_e      state_q, state_d;
    logic [1:0]  pos_x_q, pos_x_d;
    logic [1:0]  pos_y_q, pos_y_d;
    logic [0:17] board_q, board_d;
    logic [3:0]  move_cnt_q, move_cnt_d;
    logic [2:0]  line_q, line_d;
    logic        turn_q, turn_d;
    logic [14:0] win_seq_q, win_seq_d;
    logic        win_flag_q, draw_flag_q;

    // Cells of line l as {first, second, third}, in scan order rows, columns, diagonals.
    function automatic logic [11:0] line_cells(input logic [2:0] l);
        case (l)
            3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
            3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
            3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
            3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
            3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
            3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
            3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
            default: line_cells = {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    logic [11:0] cells;
    logic [3:0]  ca, cb, cc;
    logic [1:0]  va, vb, vc;
    logic        line_match;
    logic [3:0]  cur_cell;
    logic [1:0]  cur_val;

    assign cells      = line_cells(line_q);
    assign ca         = cells[11:8];
    assign cb         = cells[7:4];
    assign cc         = cells[3:0];
    assign va         = board_q[{ca, 1'b0} +: 2];
    assign vb         = board_q[{cb, 1'b0} +: 2];
    assign vc         = board_q[{cc, 1'b0} +: 2];
    assign line_match = (va != 2'b00) && (va == vb) && (va == vc);

    assign cur_cell = {2'b00, pos_x_q} + {1'b0, pos_y_q, 1'b0} + {2'b00, pos_y_q};
    assign cur_val  = board_q[{cur_cell, 1'b0} +: 2];

    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        board_d    = board_q;
        move_cnt_d = move_cnt_q;
        line_d     = line_q;
        turn_d     = turn_q;
        win_seq_d  = win_seq_q;

        case (state_q)
            S_PLAY: begin
                if (p_sel) begin
                    if (cur_val == 2'b00) begin
                        board_d[{cur_cell, 1'b0} +: 2] = turn_q ? 2'b10 : 2'b01;
                        move_cnt_d = move_cnt_q + 4'd1;
                        line_d     = 3'd0;
                        state_d    = S_CHECK;
                    end
                end else if (p_up) begin
                    pos_y_d = (pos_y_q == 2'd0) ? 2'd2 : pos_y_q - 2'd1;
                end else if (p_down) begin
                    pos_y_d = (pos_y_q == 2'd2) ? 2'd0 : pos_y_q + 2'd1;
                end else if (p_left) begin
                    pos_x_d = (pos_x_q == 2'd0) ? 2'd2 : pos_x_q - 2'd1;
                end else if (p_right) begin
                    pos_x_d = (pos_x_q == 2'd2) ? 2'd0 : pos_x_q + 2'd1;
                end
            end
            S_CHECK: begin
                if (line_match) begin
                    win_seq_d = {cc, 1'b0, cb, 1'b0, ca, 1'b0};
                    state_d   = S_WIN;
                end else if (line_q == 3'd7) begin
                    if (move_cnt_q == 4'd9) begin
                        state_d = S_DRAW;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = S_PLAY;
                    end
                end else begin
                    line_d = line_q + 3'd1;
                end
            end
            S_WIN, S_DRAW: begin
                if (p_sel) begin
                    board_d    = '0;
                    win_seq_d  = '0;
                    move_cnt_d = '0;
                    turn_d     = 1'b0;
                    state_d    = S_PLAY;
                end
            end
            default: state_d = S_PLAY;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_PLAY;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            board_q     <= '0;
            move_cnt_q  <= '0;
            line_q      <= '0;
            turn_q      <= 1'b0;
            win_seq_q   <= '0;
            win_flag_q  <= 1'b0;
            draw_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            board_q     <= board_d;
            move_cnt_q  <= move_cnt_d;
            line_q      <= line_d;
            turn_q      <= turn_d;
            win_seq_q   <= win_seq_d;
            win_flag_q  <= (state_d == S_WIN);
            draw_flag_q <= (state_d == S_DRAW);
        end
    end

    assign oMarkedBlockPosX = {2'b00, pos_x_q};
    assign oMarkedBlockPosY = {2'b00, pos_y_q};
    assign oSymVector       = board_q;
    assign oWinSeqPos       = win_seq_q;
    assign oWinFlag         = win_flag_q;
    assign oDrawFlag        = draw_flag_q;
    assign oTurn            = turn_q;

endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// Scoreboard bench for tictactoe_game_ctrl: a behavioural game model queues the expected
// outputs per button transaction; they are compared once the DUT has settled.
module tb_tictactoe_game_ctrl;

    localparam int DB = 4;
`ifdef TTT_BTN_DEBOUNCE_EN
    localparam int LAT    = 3 + DB;
    localparam int HOLD   = 12;
    localparam int SETTLE = 40;
`else
    localparam int LAT    = 3;
    localparam int HOLD   = 4;
    localparam int SETTLE = 20;
`endif

    localparam logic [4:0] B_SEL   = 5'b10000;
    localparam logic [4:0] B_UP    = 5'b01000;
    localparam logic [4:0] B_DOWN  = 5'b00100;
    localparam logic [4:0] B_LEFT  = 5'b00010;
    localparam logic [4:0] B_RIGHT = 5'b00001;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        iBtnUp = 1'b0, iBtnDown = 1'b0, iBtnLeft = 1'b0, iBtnRight = 1'b0, iBtnSelect = 1'b0;
    logic [3:0]  oMarkedBlockPosX, oMarkedBlockPosY;
    logic [0:17] oSymVector;
    logic [14:0] oWinSeqPos;
    logic        oWinFlag, oDrawFlag, oTurn;

    tictactoe_game_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .iBtnUp           (iBtnUp),
        .iBtnDown         (iBtnDown),
        .iBtnLeft         (iBtnLeft),
        .iBtnRight        (iBtnRight),
        .iBtnSelect       (iBtnSelect),
        .oMarkedBlockPosX (oMarkedBlockPosX),
        .oMarkedBlockPosY (oMarkedBlockPosY),
        .oSymVector       (oSymVector),
        .oWinSeqPos       (oWinSeqPos),
        .oWinFlag         (oWinFlag),
        .oDrawFlag        (oDrawFlag),
        .oTurn            (oTurn)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [0:17] sym;
        logic [3:0]  x;
        logic [3:0]  y;
        logic        turn;
        logic        win;
        logic        draw;
        logic [14:0] seq;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_txn    = 0;

    // Game model
    int          m_cell[9];
    int          m_x, m_y, m_turn, m_moves, m_mode;  // mode: 0 play, 1 win, 2 draw
    logic [14:0] m_seq;
    int          lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                 '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [0:17] model_sym();
        logic [0:17] s = '0;
        for (int k = 0; k < 9; k++) s[2*k +: 2] = 2'(m_cell[k]);
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 9; k++) m_cell[k] = 0;
        m_x = 0; m_y = 0; m_turn = 0; m_moves = 0; m_mode = 0; m_seq = '0;
    endtask

    task automatic sb_push();
        exp_t e;
        e.sym  = model_sym();
        e.x    = 4'(m_x);
        e.y    = 4'(m_y);
        e.turn = 1'(m_turn);
        e.win  = (m_mode == 1);
        e.draw = (m_mode == 2);
        e.seq  = m_seq;
        sb_q.push_back(e);
    endtask

    task automatic sb_compare(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val({name, "/sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check_val({name, "/sym"},  32'(oSymVector),       32'(e.sym));
        check_val({name, "/x"},    32'(oMarkedBlockPosX), 32'(e.x));
        check_val({name, "/y"},    32'(oMarkedBlockPosY), 32'(e.y));
        check_val({name, "/turn"}, 32'(oTurn),            32'(e.turn));
        check_val({name, "/win"},  32'(oWinFlag),         32'(e.win));
        check_val({name, "/draw"}, 32'(oDrawFlag),        32'(e.draw));
        check_val({name, "/seq"},  32'(oWinSeqPos),       32'(e.seq));
        n_txn++;
        $display("txn %0d %s: cursor=(%0d,%0d) sym=%b turn=%0d win=%0d draw=%0d seq=%h",
                 n_txn, name, oMarkedBlockPosX, oMarkedBlockPosY, oSymVector, oTurn,
                 oWinFlag, oDrawFlag, oWinSeqPos);
    endtask

    task automatic model_apply(input logic [4:0] m, output int flag_lat, output bit placed);
        int k, hit;
        flag_lat = -1;
        placed   = 0;
        if (m_mode == 0) begin
            if (m[4]) begin
                k = m_x + 3 * m_y;
                if (m_cell[k] == 0) begin
                    m_cell[k] = (m_turn != 0) ? 2 : 1;
                    m_moves++;
                    placed = 1;
                    hit = -1;
                    for (int l = 0; l < 8; l++) begin
                        if (hit < 0 && m_cell[lines[l][0]] != 0 &&
                            m_cell[lines[l][0]] == m_cell[lines[l][1]] &&
                            m_cell[lines[l][0]] == m_cell[lines[l][2]]) hit = l;
                    end
                    if (hit >= 0) begin
                        m_mode   = 1;
                        m_seq    = {5'(2*lines[hit][2]), 5'(2*lines[hit][1]), 5'(2*lines[hit][0])};
                        flag_lat = LAT + hit + 1;
                    end else if (m_moves == 9) begin
                        m_mode   = 2;
                        flag_lat = LAT + 8;
                    end else begin
                        m_turn = 1 - m_turn;
                    end
                end
            end else if (m[3]) m_y = (m_y + 2) % 3;
            else if (m[2])     m_y = (m_y + 1) % 3;
            else if (m[1])     m_x = (m_x + 2) % 3;
            else if (m[0])     m_x = (m_x + 1) % 3;
        end else if (m[4]) begin
            for (int c = 0; c < 9; c++) m_cell[c] = 0;
            m_seq = '0; m_moves = 0; m_turn = 0; m_mode = 0;
        end
    endtask

    task automatic drive_btns(input logic [4:0] m);
        {iBtnSelect, iBtnUp, iBtnDown, iBtnLeft, iBtnRight} = m;
    endtask

    // drv is what reaches the pins, mdl is what the model should register as a press.
    task automatic do_press(input logic [4:0] drv, input logic [4:0] mdl, input int hold,
                            input string name);
        logic [0:17] sym_before, sym_after;
        int          flag_lat, seen;
        bit          placed;
        sym_before = model_sym();
        model_apply(mdl, flag_lat, placed);
        sym_after = model_sym();
        sb_push();
        seen = -1;
        @(negedge Clock);
        drive_btns(drv);
        for (int c = 1; c <= SETTLE; c++) begin
            @(negedge Clock);
            if (c == hold) drive_btns(5'b0);
            if (placed && c == LAT - 1) check_val({name, "/sym_pre"}, 32'(oSymVector), 32'(sym_before));
            if (placed && c == LAT)     check_val({name, "/sym_edge"}, 32'(oSymVector), 32'(sym_after));
            if (flag_lat >= 0 && seen < 0 && (oWinFlag || oDrawFlag)) seen = c;
        end
        drive_btns(5'b0);
        if (flag_lat >= 0) check_val({name, "/end_latency"}, 32'(seen), 32'(flag_lat));
        sb_compare(name);
    endtask

    task automatic goto_cell(input int tx, input int ty);
        for (int g = 0; g < 3 && m_x != tx; g++) do_press(B_RIGHT, B_RIGHT, HOLD, "right");
        for (int g = 0; g < 3 && m_y != ty; g++) do_press(B_DOWN, B_DOWN, HOLD, "down");
    endtask

    task automatic place(input int tx, input int ty);
        goto_cell(tx, ty);
        do_press(B_SEL, B_SEL, HOLD, "place");
    endtask

    task automatic check_all_zero(input string name);
        check_val({name, "/sym"},  32'(oSymVector), 32'd0);
        check_val({name, "/x"},    32'(oMarkedBlockPosX), 32'd0);
        check_val({name, "/y"},    32'(oMarkedBlockPosY), 32'd0);
        check_val({name, "/turn"}, 32'(oTurn), 32'd0);
        check_val({name, "/win"},  32'(oWinFlag), 32'd0);
        check_val({name, "/draw"}, 32'(oDrawFlag), 32'd0);
        check_val({name, "/seq"},  32'(oWinSeqPos), 32'd0);
    endtask

    initial begin
        model_reset();
        #2 Reset = 1'b0;
        #1 check_all_zero("reset_init");
        repeat (2) @(negedge Clock);
        Reset = 1'b1;

        // Cursor wrap in every direction
        do_press(B_LEFT,  B_LEFT,  HOLD, "left_wrap");
        check_val("left_wrap_x2", 32'(oMarkedBlockPosX), 32'd2);
        do_press(B_RIGHT, B_RIGHT, HOLD, "right_wrap");
        do_press(B_UP,    B_UP,    HOLD, "up_wrap");
        check_val("up_wrap_y2", 32'(oMarkedBlockPosY), 32'd2);
        do_press(B_DOWN,  B_DOWN,  HOLD, "down_wrap");

        // All five at once: only select acts
        do_press(5'b11111, 5'b11111, HOLD, "all_buttons");
        do_press(B_SEL, B_SEL, HOLD, "occupied_sel");

        // Top-row win for X
        place(0, 1);
        place(1, 0);
        place(1, 1);
        place(2, 0);
        check_val("top_win_seq", 32'(oWinSeqPos), 32'({5'd4, 5'd2, 5'd0}));
        do_press(B_RIGHT, B_RIGHT, HOLD, "move_in_win");
        do_press(B_SEL, B_SEL, HOLD, "restart_win");

        // Anti-diagonal win for O
        place(0, 0);
        place(2, 0);
        place(1, 0);
        place(1, 1);
        place(2, 1);
        place(0, 2);
        check_val("anti_diag_seq", 32'(oWinSeqPos), 32'({5'd12, 5'd8, 5'd4}));
        do_press(B_SEL, B_SEL, HOLD, "restart_diag");

        // Draw: X,O,X / X,O,O / O,X,X
        place(0, 0); place(1, 0); place(2, 0); place(1, 1); place(0, 1);
        place(2, 1); place(1, 2); place(0, 2); place(2, 2);
        check_val("draw_flag", 32'(oDrawFlag), 32'd1);
        do_press(B_SEL, B_SEL, HOLD, "restart_draw");
        check_val("restart_sym", 32'(oSymVector), 32'd0);
        check_val("restart_turn", 32'(oTurn), 32'd0);

`ifdef TTT_BTN_DEBOUNCE_EN
        do_press(B_RIGHT, 5'b0, 3, "glitch_right");
        do_press(B_RIGHT, B_RIGHT, 10, "long_right");
`endif

        // Reset asserted mid-CHECK after a move
        place(m_x, m_y);
        do_press(B_RIGHT, B_RIGHT, HOLD, "pre_reset_move");
        @(negedge Clock);
        drive_btns(B_SEL);
        repeat (LAT + 3) @(negedge Clock);
        #2 Reset = 1'b0;
        #1 check_all_zero("reset_async");
        drive_btns(5'b0);
        model_reset();
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        sb_push();
        repeat (SETTLE) @(negedge Clock);
        sb_compare("after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
